// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream payload in,
// registered payload out.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 256
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer, flush, and a
// saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int WIDTH = 256,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rset,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             in_ready_w;

  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Acceptance is implied by state: EMPTY always accepts, BUSY accepts when a
  // skid slot exists or the downstream drains, FULL never accepts.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (bus.in_valid) begin
            state_d = BUSY;
            main_d  = bus.in_data;
          end
        end
        BUSY: begin
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              main_d = bus.in_data;
            end else begin
              state_d = EMPTY;
            end
          end else if (bus.in_valid && (SKID != 0)) begin
            state_d = FULL;
            skid_d  = bus.in_data;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready cuts the combinational out_ready -> in_ready path.
      logic in_ready_q;
      always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != FULL);
        end
      end
      assign in_ready_w = in_ready_q;
    end else begin : g_noskid
      assign in_ready_w = (state_q == EMPTY) || bus.out_ready;
    end
  endgenerate

  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      stall_cnt_q <= '0;
    end else if ((state_q != EMPTY) && !bus.out_ready && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign occupancy     = state_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: scoreboard of accepted payloads compared against the
// stage output, plus directed checks for flush, counter and async reset.
module tb_pipe_stage_reg;
  logic       clk = 1'b0;
  logic       rset;
  logic       flush1, flush0;
  logic [1:0] occ1, occ0;
  logic [3:0] cnt1, cnt0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [31:0] sb1[$];
  logic [31:0] sb0[$];

  pipe_stage_reg_if #(.WIDTH(32)) if1 ();
  pipe_stage_reg_if #(.WIDTH(32)) if0 ();

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(4)) dut1 (
    .clk(clk), .rset(rset), .flush(flush1), .bus(if1),
    .occupancy(occ1), .stall_cnt(cnt1)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rset(rset), .flush(flush0), .bus(if0),
    .occupancy(occ0), .stall_cnt(cnt0)
  );

  always #5 clk = ~clk;

  // Inputs change 1 after the rising edge; checks happen mid-cycle.
  task automatic step1(input logic v, input logic [31:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    if1.in_valid = v; if1.in_data = d; if1.out_ready = r; flush1 = f;
    #4;
  endtask

  task automatic step0(input logic v, input logic [31:0] d, input logic r);
    @(posedge clk);
    #1;
    if0.in_valid = v; if0.in_data = d; if0.out_ready = r;
    #4;
  endtask

  task automatic test_reset();
    rset = 1'b1; flush1 = 1'b0; flush0 = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0;
    #22;
    n_cmp++; if (if1.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", if1.out_valid); end
    n_cmp++; if (occ1 !== 2'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", occ1); end
    n_cmp++; if (if1.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", if1.in_ready); end
    n_cmp++; if (cnt1 !== 4'd0) begin n_err++; $display("FAIL reset_stall_cnt got=%0d exp=0", cnt1); end
    n_cmp++; if (if1.out_data !== 32'd0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", if1.out_data); end
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_skid0 got=%b exp=1", if0.in_ready); end
    rset = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] e;
    sb1.delete();
    for (int i = 0; i < 6; i++) begin
      step1(i < 4, 32'(i + 1), 1'b1, 1'b0);
      n_cmp++; if (occ1 !== 2'(sb1.size())) begin n_err++; $display("FAIL stream_occ cyc=%0d got=%0d exp=%0d", i, occ1, sb1.size()); end
      n_cmp++; if (if1.out_valid !== (sb1.size() != 0)) begin n_err++; $display("FAIL stream_out_valid cyc=%0d got=%b", i, if1.out_valid); end
      if (if1.out_valid && if1.out_ready) begin
        n_cmp++;
        if (sb1.size() == 0) begin n_err++; $display("FAIL stream_extra got=%h exp=none", if1.out_data); end
        else begin
          e = sb1.pop_front();
          if (if1.out_data !== e) begin n_err++; $display("FAIL stream_data got=%h exp=%h", if1.out_data, e); end
          else $display("stream out %h", if1.out_data);
        end
      end
      if (if1.in_valid && if1.in_ready) sb1.push_back(if1.in_data);
    end
    n_cmp++; if (sb1.size() != 0) begin n_err++; $display("FAIL stream_drain got=%0d left exp=0", sb1.size()); end
  endtask

  task automatic test_backpressure();
    logic        tv[7] = '{1, 1, 1, 1, 1, 0, 0};
    logic [31:0] td[7] = '{32'hA, 32'hB, 32'hC, 32'hC, 32'hC, 32'h0, 32'h0};
    logic        tr[7] = '{0, 0, 0, 1, 1, 1, 1};
    logic [31:0] e;
    sb1.delete();
    for (int i = 0; i < 7; i++) begin
      step1(tv[i], td[i], tr[i], 1'b0);
      n_cmp++; if (occ1 !== 2'(sb1.size())) begin n_err++; $display("FAIL bp_occ cyc=%0d got=%0d exp=%0d", i, occ1, sb1.size()); end
      n_cmp++; if (if1.in_ready !== (sb1.size() < 2)) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b", i, if1.in_ready); end
      if (if1.out_valid && !if1.out_ready && sb1.size() != 0) begin
        n_cmp++; if (if1.out_data !== sb1[0]) begin n_err++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, if1.out_data, sb1[0]); end
      end
      if (if1.out_valid && if1.out_ready) begin
        n_cmp++;
        if (sb1.size() == 0) begin n_err++; $display("FAIL bp_extra got=%h exp=none", if1.out_data); end
        else begin
          e = sb1.pop_front();
          if (if1.out_data !== e) begin n_err++; $display("FAIL bp_data got=%h exp=%h", if1.out_data, e); end
          else $display("bp out %h", if1.out_data);
        end
      end
      if (if1.in_valid && if1.in_ready) sb1.push_back(if1.in_data);
    end
    n_cmp++; if (sb1.size() != 0) begin n_err++; $display("FAIL bp_drain got=%0d left exp=0", sb1.size()); end
  endtask

  task automatic test_flush();
    logic        tv[5] = '{1, 1, 1, 0, 0};
    logic [31:0] td[5] = '{32'h5, 32'h6, 32'h7, 32'h0, 32'h0};
    logic        tr[5] = '{0, 0, 0, 1, 1};
    logic        tf[5] = '{0, 0, 1, 0, 0};
    sb1.delete();
    for (int i = 0; i < 5; i++) begin
      step1(tv[i], td[i], tr[i], tf[i]);
      n_cmp++; if (occ1 !== 2'(sb1.size())) begin n_err++; $display("FAIL flush_occ cyc=%0d got=%0d exp=%0d", i, occ1, sb1.size()); end
      n_cmp++; if (if1.out_valid !== (sb1.size() != 0)) begin n_err++; $display("FAIL flush_out_valid cyc=%0d got=%b", i, if1.out_valid); end
      if (i >= 3) begin
        n_cmp++; if (if1.out_data !== 32'd0) begin n_err++; $display("FAIL flush_out_data cyc=%0d got=%h exp=0", i, if1.out_data); end
      end
      if (flush1) sb1.delete();
      else if (if1.in_valid && if1.in_ready) sb1.push_back(if1.in_data);
    end
    $display("flush done occ=%0d", occ1);
  endtask

  task automatic test_async_reset();
    step1(1'b1, 32'h11, 1'b0, 1'b0);
    step1(1'b1, 32'h22, 1'b0, 1'b0);
    step1(1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (occ1 !== 2'd2) begin n_err++; $display("FAIL areset_pre_occ got=%0d exp=2", occ1); end
    rset = 1'b1;
    #1;
    n_cmp++; if (if1.out_valid !== 1'b0) begin n_err++; $display("FAIL areset_out_valid got=%b exp=0", if1.out_valid); end
    n_cmp++; if (occ1 !== 2'd0) begin n_err++; $display("FAIL areset_occ got=%0d exp=0", occ1); end
    n_cmp++; if (if1.in_ready !== 1'b1) begin n_err++; $display("FAIL areset_in_ready got=%b exp=1", if1.in_ready); end
    n_cmp++; if (if1.out_data !== 32'd0) begin n_err++; $display("FAIL areset_out_data got=%h exp=0", if1.out_data); end
    #2;
    rset = 1'b0;
    step1(1'b1, 32'h99, 1'b1, 1'b0);
    n_cmp++; if (if1.out_valid !== 1'b0) begin n_err++; $display("FAIL areset_stale got=%b exp=0", if1.out_valid); end
    step1(1'b0, 32'h0, 1'b1, 1'b0);
    n_cmp++; if (if1.out_valid !== 1'b1 || if1.out_data !== 32'h99) begin
      n_err++; $display("FAIL areset_first got=%b/%h exp=1/00000099", if1.out_valid, if1.out_data);
    end
    step1(1'b0, 32'h0, 1'b1, 1'b0);
    $display("async reset done occ=%0d", occ1);
  endtask

  task automatic test_counter();
    int exp_cnt;
    rset = 1'b1; #1; rset = 1'b0;
    exp_cnt = 0;
    step1(1'b1, 32'h33, 1'b0, 1'b0);
    for (int k = 0; k < 21; k++) begin
      step1(1'b0, 32'h0, 1'b0, 1'b0);
      n_cmp++; if (cnt1 !== 4'(exp_cnt)) begin n_err++; $display("FAIL cnt_step k=%0d got=%0d exp=%0d", k, cnt1, exp_cnt); end
      if (exp_cnt < 15) exp_cnt++;
    end
    step1(1'b0, 32'h0, 1'b0, 1'b1);
    step1(1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (cnt1 !== 4'd15) begin n_err++; $display("FAIL cnt_after_flush got=%0d exp=15", cnt1); end
    n_cmp++; if (if1.out_valid !== 1'b0) begin n_err++; $display("FAIL cnt_flush_valid got=%b exp=0", if1.out_valid); end
    rset = 1'b1; #1;
    n_cmp++; if (cnt1 !== 4'd0) begin n_err++; $display("FAIL cnt_reset got=%0d exp=0", cnt1); end
    rset = 1'b0;
    $display("counter done");
  endtask

  task automatic test_skid0();
    logic [31:0] e;
    sb0.delete();
    for (int i = 0; i < 11; i++) begin
      step0(i < 10, 32'h100 + 32'(i), (i % 2) == 0);
      n_cmp++; if (occ0 !== 2'(sb0.size()) || occ0 > 2'd1) begin n_err++; $display("FAIL s0_occ cyc=%0d got=%0d exp=%0d", i, occ0, sb0.size()); end
      n_cmp++; if (if0.in_ready !== ((sb0.size() == 0) || if0.out_ready)) begin n_err++; $display("FAIL s0_in_ready cyc=%0d got=%b", i, if0.in_ready); end
      if (if0.out_valid && if0.out_ready) begin
        n_cmp++;
        if (sb0.size() == 0) begin n_err++; $display("FAIL s0_extra got=%h exp=none", if0.out_data); end
        else begin
          e = sb0.pop_front();
          if (if0.out_data !== e) begin n_err++; $display("FAIL s0_data got=%h exp=%h", if0.out_data, e); end
          else $display("skid0 out %h", if0.out_data);
        end
      end
      if (if0.in_valid && if0.in_ready) sb0.push_back(if0.in_data);
    end
    step0(1'b0, 32'h0, 1'b1);
    n_cmp++; if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL s0_drain got=%b exp=0", if0.out_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_counter();
    test_skid0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
